// File: rtl/otter_ir_pipeline.sv
// -----------------------------------------------------------------------------
// otter_ir_pipeline
//
// Instruction/PC register chain for the pipelined OTTER RV32I core. Each
// fetched instruction is carried through the DEC, EXE, MEM and WB stage
// registers. The chain detects load-use hazards (DEC holds, a bubble enters
// EXE), squashes the DEC slot on a taken control transfer, freezes entirely
// while data memory is busy, and counts the cycles in which fetch is held.
//
// Parameters
//   NOP_INSTR  bubble encoding (addi x0,x0,0)
//   CNT_W      width of the saturating stall counter
//
// Ports
//   CLK, RST_N                rising-edge clock, async active-low reset
//   IF_IR, IF_PC, IF_VALID    fetched instruction, its PC, and its valid flag
//   CLEAR                     squash the instruction entering DEC
//   MEM_STALL                 freeze every stage register
//   {DEC,EXE,MEM,WB}_IR/PC    stage instruction and PC registers
//   {DEC,EXE,MEM,WB}_VALID    stage holds a real instruction
//   PC_HOLD                   combinational: fetch must not advance this cycle
//   HAZARD                    combinational: load-use stall active
//   STALL_CNT                 saturating count of cycles with PC_HOLD=1
// -----------------------------------------------------------------------------
module otter_ir_pipeline #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [31:0]      IF_IR,
    input  logic [31:0]      IF_PC,
    input  logic             IF_VALID,
    input  logic             CLEAR,
    input  logic             MEM_STALL,
    output logic [31:0]      DEC_IR,
    output logic [31:0]      EXE_IR,
    output logic [31:0]      MEM_IR,
    output logic [31:0]      WB_IR,
    output logic [31:0]      DEC_PC,
    output logic [31:0]      EXE_PC,
    output logic [31:0]      MEM_PC,
    output logic [31:0]      WB_PC,
    output logic             DEC_VALID,
    output logic             EXE_VALID,
    output logic             MEM_VALID,
    output logic             WB_VALID,
    output logic             PC_HOLD,
    output logic             HAZARD,
    output logic [CNT_W-1:0] STALL_CNT
);

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        logic        valid;
    } stage_t;

    localparam stage_t BUBBLE = '{ir: NOP_INSTR, pc: 32'h0, valid: 1'b0};

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    stage_t dec_q, exe_q, mem_q, wb_q;
    stage_t dec_d, exe_d, mem_d, wb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // ---------------------------------------------------------------- hazard
    logic [6:0] dec_op;
    logic [4:0] exe_rd;
    logic       exe_is_load;
    logic       rs1_used;
    logic       rs2_used;

    assign dec_op      = dec_q.ir[6:0];
    assign exe_rd      = exe_q.ir[11:7];
    // A load into x0 produces nothing to wait for, so it never stalls.
    assign exe_is_load = exe_q.valid && (exe_q.ir[6:0] == OP_LOAD) && (exe_rd != 5'd0);
    assign rs1_used    = !((dec_op == OP_LUI) || (dec_op == OP_AUIPC) || (dec_op == OP_JAL));
    assign rs2_used    = (dec_op == OP_BRANCH) || (dec_op == OP_STORE) || (dec_op == OP_OP);

    assign HAZARD  = exe_is_load && dec_q.valid &&
                     ((rs1_used && (dec_q.ir[19:15] == exe_rd)) ||
                      (rs2_used && (dec_q.ir[24:20] == exe_rd)));
    assign PC_HOLD = MEM_STALL | HAZARD;

    // ------------------------------------------------------------ next state
    // NOTE: every signal driven here gets a value before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        dec_d = dec_q;
        exe_d = exe_q;
        mem_d = mem_q;
        wb_d  = wb_q;

        if (MEM_STALL) begin
            // Global freeze: CLEAR and HAZARD have no effect.
        end else if (HAZARD) begin
            // DEC waits for the load; CLEAR is ignored because the branch
            // decision in DEC depends on the pending load value.
            exe_d = BUBBLE;
            mem_d = exe_q;
            wb_d  = mem_q;
        end else begin
            wb_d  = mem_q;
            mem_d = exe_q;
            exe_d = dec_q;
            if (CLEAR || !IF_VALID) begin
                dec_d = BUBBLE;
            end else begin
                dec_d = '{ir: IF_IR, pc: IF_PC, valid: 1'b1};
            end
        end

        cnt_d = cnt_q;
        if (PC_HOLD && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------- registers
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others, giving a true shift chain.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dec_q <= BUBBLE;
            exe_q <= BUBBLE;
            mem_q <= BUBBLE;
            wb_q  <= BUBBLE;
            cnt_q <= '0;
        end else begin
            dec_q <= dec_d;
            exe_q <= exe_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

    // --------------------------------------------------------------- outputs
    assign DEC_IR    = dec_q.ir;
    assign DEC_PC    = dec_q.pc;
    assign DEC_VALID = dec_q.valid;
    assign EXE_IR    = exe_q.ir;
    assign EXE_PC    = exe_q.pc;
    assign EXE_VALID = exe_q.valid;
    assign MEM_IR    = mem_q.ir;
    assign MEM_PC    = mem_q.pc;
    assign MEM_VALID = mem_q.valid;
    assign WB_IR     = wb_q.ir;
    assign WB_PC     = wb_q.pc;
    assign WB_VALID  = wb_q.valid;
    assign STALL_CNT = cnt_q;

endmodule

// File: tb/tb_otter_ir_pipeline.sv
// -----------------------------------------------------------------------------
// tb_otter_ir_pipeline
//
// Self-checking bench for otter_ir_pipeline. A behavioural model keeps the
// four stages as an array and applies the stall/bubble/advance rules directly.
// Directed sequences cover reset, straight-line flow, load-use, false-hazard
// cases, CLEAR and stall priority; a randomized phase follows. A second
// instance with a 3-bit counter exercises stall-counter saturation.
// -----------------------------------------------------------------------------
module tb_otter_ir_pipeline;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        logic        v;
    } st_t;

    localparam st_t BUB = '{ir: NOP, pc: 32'h0, v: 1'b0};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_ir;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        clear;
    logic        mem_stall;

    logic [31:0] dec_ir, exe_ir, mem_ir, wb_ir;
    logic [31:0] dec_pc, exe_pc, mem_pc, wb_pc;
    logic        dec_v, exe_v, mem_v, wb_v;
    logic        pc_hold, hazard;
    logic [15:0] stall_cnt;

    logic [31:0] s_dec_ir, s_exe_ir, s_mem_ir, s_wb_ir;
    logic [31:0] s_dec_pc, s_exe_pc, s_mem_pc, s_wb_pc;
    logic        s_dec_v, s_exe_v, s_mem_v, s_wb_v;
    logic        s_pc_hold, s_hazard;
    logic [2:0]  s_stall_cnt;

    always #5 clk = ~clk;

    otter_ir_pipeline dut (
        .CLK(clk), .RST_N(rst_n), .IF_IR(if_ir), .IF_PC(if_pc), .IF_VALID(if_valid),
        .CLEAR(clear), .MEM_STALL(mem_stall),
        .DEC_IR(dec_ir), .EXE_IR(exe_ir), .MEM_IR(mem_ir), .WB_IR(wb_ir),
        .DEC_PC(dec_pc), .EXE_PC(exe_pc), .MEM_PC(mem_pc), .WB_PC(wb_pc),
        .DEC_VALID(dec_v), .EXE_VALID(exe_v), .MEM_VALID(mem_v), .WB_VALID(wb_v),
        .PC_HOLD(pc_hold), .HAZARD(hazard), .STALL_CNT(stall_cnt)
    );

    otter_ir_pipeline #(.CNT_W(3)) dut_s (
        .CLK(clk), .RST_N(rst_n), .IF_IR(if_ir), .IF_PC(if_pc), .IF_VALID(if_valid),
        .CLEAR(clear), .MEM_STALL(mem_stall),
        .DEC_IR(s_dec_ir), .EXE_IR(s_exe_ir), .MEM_IR(s_mem_ir), .WB_IR(s_wb_ir),
        .DEC_PC(s_dec_pc), .EXE_PC(s_exe_pc), .MEM_PC(s_mem_pc), .WB_PC(s_wb_pc),
        .DEC_VALID(s_dec_v), .EXE_VALID(s_exe_v), .MEM_VALID(s_mem_v), .WB_VALID(s_wb_v),
        .PC_HOLD(s_pc_hold), .HAZARD(s_hazard), .STALL_CNT(s_stall_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ----------------------------------------------------------------- model
    st_t m[4];          // 0=DEC 1=EXE 2=MEM 3=WB
    int  m_cnt;
    int  m_cnt_s;

    function automatic bit m_hazard();
        logic [6:0] op;
        logic [4:0] rd;
        bit use1, use2;
        op = m[0].ir[6:0];
        rd = m[1].ir[11:7];
        if (!m[1].v || m[1].ir[6:0] != 7'b0000011 || rd == 5'd0 || !m[0].v) return 1'b0;
        use1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
        use2 = op inside {7'b1100011, 7'b0100011, 7'b0110011};
        return (use1 && m[0].ir[19:15] == rd) || (use2 && m[0].ir[24:20] == rd);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 4; i++) m[i] = BUB;
        m_cnt   = 0;
        m_cnt_s = 0;
    endtask

    task automatic cmp_all();
        bit hz;
        hz = m_hazard();
        check("dec_ir", dec_ir, m[0].ir);   check("dec_pc", dec_pc, m[0].pc);
        check("dec_v", 32'(dec_v), 32'(m[0].v));
        check("exe_ir", exe_ir, m[1].ir);   check("exe_pc", exe_pc, m[1].pc);
        check("exe_v", 32'(exe_v), 32'(m[1].v));
        check("mem_ir", mem_ir, m[2].ir);   check("mem_pc", mem_pc, m[2].pc);
        check("mem_v", 32'(mem_v), 32'(m[2].v));
        check("wb_ir", wb_ir, m[3].ir);     check("wb_pc", wb_pc, m[3].pc);
        check("wb_v", 32'(wb_v), 32'(m[3].v));
        check("hazard", 32'(hazard), 32'(hz));
        check("pc_hold", 32'(pc_hold), 32'(hz || mem_stall));
        check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        check("stall_cnt_s", 32'(s_stall_cnt), 32'(m_cnt_s));
    endtask

    // One clock: inputs must already be driven. Model next state is computed
    // from the pre-edge state and inputs, then compared after the edge.
    task automatic step();
        st_t nx[4];
        bit  hz;
        #1;
        hz = m_hazard();
        check("hazard_pre", 32'(hazard), 32'(hz));
        check("pc_hold_pre", 32'(pc_hold), 32'(hz || mem_stall));
        nx = m;
        if (mem_stall) begin
        end else if (hz) begin
            nx[3] = m[2]; nx[2] = m[1]; nx[1] = BUB;
        end else begin
            nx[3] = m[2]; nx[2] = m[1]; nx[1] = m[0];
            nx[0] = (clear || !if_valid) ? BUB : '{ir: if_ir, pc: if_pc, v: 1'b1};
        end
        if (hz || mem_stall) begin
            if (m_cnt   < 65535) m_cnt++;
            if (m_cnt_s < 7)     m_cnt_s++;
        end
        @(posedge clk);
        #1;
        m = nx;
        cmp_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_reset();
        cmp_all();
        @(posedge clk);
        #1;
        cmp_all();
        rst_n = 1'b1;
    endtask

    task automatic feed(input logic [31:0] ir, input logic [31:0] pc);
        if_ir = ir; if_pc = pc; if_valid = 1'b1;
        step();
    endtask

    task automatic idle();
        if_valid = 1'b0; clear = 1'b0; mem_stall = 1'b0;
    endtask

    function automatic logic [31:0] gen_instr();
        logic [6:0] ops [8];
        ops = '{7'b0000011, 7'b0110011, 7'b1100011, 7'b0100011,
                7'b0110111, 7'b0010111, 7'b1101111, 7'b0010011};
        return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                3'($urandom), 5'($urandom_range(0, 3)), ops[$urandom_range(0, 7)]};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        rst_n = 1'b0; if_ir = NOP; if_pc = 32'h0; if_valid = 1'b0;
        clear = 1'b0; mem_stall = 1'b0;
        m_reset();
        @(posedge clk); #1;
        do_reset();

        // Straight line
        feed(32'h00500093, 32'h0);
        feed(32'h00A00113, 32'h4);
        feed(32'h002081B3, 32'h8);
        idle();
        check("line_hold", 32'(pc_hold), 32'h0);
        step();
        check("line_wb0", wb_ir, 32'h00500093);
        step();
        check("line_wb1", wb_ir, 32'h00A00113);
        step();
        check("line_wb2", wb_ir, 32'h002081B3);
        check("line_cnt", 32'(stall_cnt), 32'h0);

        // Load-use
        do_reset();
        feed(32'h0000A103, 32'h100);
        feed(32'h002081B3, 32'h104);
        idle();
        #1;
        check("lu_hazard", 32'(hazard), 32'h1);
        check("lu_pc_hold", 32'(pc_hold), 32'h1);
        step();
        check("lu_exe_bub", exe_ir, NOP);
        check("lu_exe_v", 32'(exe_v), 32'h0);
        check("lu_dec", dec_ir, 32'h002081B3);
        check("lu_mem", mem_ir, 32'h0000A103);
        check("lu_hz_drop", 32'(hazard), 32'h0);
        check("lu_cnt", 32'(stall_cnt), 32'h1);
        step();
        check("lu_adv", exe_ir, 32'h002081B3);

        // Async reset with a LOAD in EXE
        do_reset();
        feed(32'h0000A103, 32'h200);
        feed(32'h002081B3, 32'h204);
        idle();
        step();                         // hazard cycle, counter now 1
        mem_stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_exe_ir", exe_ir, NOP);
        check("rst_dec_v", 32'(dec_v), 32'h0);
        check("rst_mem_v", 32'(mem_v), 32'h0);
        check("rst_cnt", 32'(stall_cnt), 32'h0);
        check("rst_pc_hold", 32'(pc_hold), 32'h1);
        mem_stall = 1'b0;
        @(posedge clk); #1;
        m_reset();
        cmp_all();
        rst_n = 1'b1;

        // No false hazard
        feed(32'h0000A103, 32'h300);     // lw x2
        feed(32'h00200137, 32'h304);     // lui x2
        idle(); #1;
        check("nf_lui", 32'(hazard), 32'h0);
        feed(32'h00002003, 32'h308);     // lw x0
        feed(32'h000001B3, 32'h30C);     // add x3,x0,x0
        idle(); #1;
        check("nf_x0", 32'(hazard), 32'h0);

        // CLEAR
        feed(32'h00A00113, 32'h400);
        clear = 1'b1;
        feed(32'h00100293, 32'h404);
        check("clr_dec_v", 32'(dec_v), 32'h0);
        check("clr_dec_ir", dec_ir, NOP);
        check("clr_exe", exe_ir, 32'h00A00113);
        idle();

        // Priority: MEM_STALL over HAZARD and CLEAR
        feed(32'h0000A103, 32'h500);
        feed(32'h002081B3, 32'h504);
        c0 = m_cnt;
        mem_stall = 1'b1; clear = 1'b1; if_ir = 32'h00100293; if_valid = 1'b1;
        repeat (3) step();
        check("pri_dec", dec_ir, 32'h002081B3);
        check("pri_exe", exe_ir, 32'h0000A103);
        check("pri_cnt", 32'(stall_cnt), 32'(c0 + 3));
        mem_stall = 1'b0;
        step();                          // hazard edge: CLEAR ignored
        check("pri_hz_dec", dec_ir, 32'h002081B3);
        idle();

        // Counter saturation on the 3-bit instance
        do_reset();
        mem_stall = 1'b1;
        repeat (10) step();
        check("sat_small", 32'(s_stall_cnt), 32'h7);
        check("sat_main", 32'(stall_cnt), 32'd10);
        idle();

        // Randomized phase
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                if_ir     = gen_instr();
                if_pc     = 32'(i) << 2;
                if_valid  = ($urandom_range(0, 9) < 8);
                clear     = ($urandom_range(0, 9) == 0);
                mem_stall = ($urandom_range(0, 9) == 0);
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/otter_ir_pipeline.md
# otter_ir_pipeline

Instruction/PC pipeline register chain for the pipelined OTTER RV32I core. It captures each fetched instruction and carries it through the DEC, EXE, MEM and WB stage registers. These registers are the `DEC_IR`/`EXE_IR`/`MEM_IR`/`WB_IR` words that the per-stage control decoders consume. It also performs load-use hazard detection (stall plus bubble insertion), squashes the DEC slot on control-flow `CLEAR`, freezes globally on memory stall, and counts stall cycles.

## Interface
- `NOP_INSTR`, default 32'h0000_0013, bubble encoding (`addi x0,x0,0`).
- `CNT_W`, default 16, stall counter width.

- `CLK`  in  1  rising-edge clock.
- `RST_N`  in  1  asynchronous, active-low reset.
- `IF_IR`  in  32  instruction word from instruction memory.
- `IF_PC`  in  32  PC of `IF_IR`.
- `IF_VALID`  in  1  `IF_IR`/`IF_PC` valid this cycle.
- `CLEAR`  in  1  branch/jump taken in decode; squash the instruction entering DEC.
- `MEM_STALL`  in  1  data memory busy; freeze every stage register.
- `DEC_IR`, `EXE_IR`, `MEM_IR`, `WB_IR`  out  32 each  stage instruction registers.
- `DEC_PC`, `EXE_PC`, `MEM_PC`, `WB_PC`  out  32 each  stage PC registers.
- `DEC_VALID`, `EXE_VALID`, `MEM_VALID`, `WB_VALID`  out  1 each  stage holds a real instruction.
- `PC_HOLD`  out  1  combinational; fetch must not advance PC this cycle.
- `HAZARD`  out  1  combinational; load-use stall active.
- `STALL_CNT`  out  `CNT_W`  saturating count of cycles with `PC_HOLD`=1.

## Operation
- Bubble means IR=`NOP_INSTR`, PC=0, VALID=0.
- Hazard detection (combinational, from registered state):
  - `HAZARD`=1 when all of the following hold: `EXE_VALID`; `EXE_IR[6:0]`=7'b0000011 (LOAD); `EXE_IR[11:7]`≠0; `DEC_VALID`; and a DEC source matches `EXE_IR[11:7]`.
  - rs1 (`DEC_IR[19:15]`) counts as a source for every opcode except LUI (0110111), AUIPC (0010111) and JAL (1101111).
  - rs2 (`DEC_IR[24:20]`) counts as a source only for BRANCH (1100011), STORE (0100011) and OP (0110011).
- `PC_HOLD` = `MEM_STALL` | `HAZARD`.
- Per-cycle update, highest priority first:
  1. `MEM_STALL`=1: all four stages hold. `CLEAR` and `HAZARD` are ignored.
  2. `HAZARD`=1: DEC holds; EXE loads a bubble; MEM←EXE; WB←MEM. `CLEAR` is ignored because the DEC branch decision is not yet valid.
  3. Otherwise the chain advances: WB←MEM, MEM←EXE, EXE←DEC. DEC loads a bubble if `CLEAR`=1 or `IF_VALID`=0; otherwise DEC←{`IF_IR`, `IF_PC`, 1}.
- Bubbles are forwarded like normal instructions. A stage holding a bubble never triggers `HAZARD`.
- `STALL_CNT` increments on each rising edge at which `PC_HOLD`=1. It saturates at all-ones and never wraps.

## Timing
- Reset (`RST_N`=0, asynchronous, any time, including mid-stall):
  - every IR = `NOP_INSTR`, every PC = 0, every VALID = 0, `STALL_CNT` = 0.
  - `HAZARD` and `PC_HOLD` follow their inputs combinationally; with `MEM_STALL`=0 both are 0.
- Reset release takes effect at the first rising edge after `RST_N` rises.
- Latency: an instruction presented at IF at edge n appears in DEC after edge n, EXE after n+1, MEM after n+2, WB after n+3, assuming no stalls.
- A load-use pair costs exactly 1 hazard cycle. After one bubble the LOAD sits in MEM, so `HAZARD` drops.
- `HAZARD` and `PC_HOLD` are valid in the same cycle as the registered state; fetch samples `PC_HOLD` before the next edge.
- `MEM_STALL` held for k cycles freezes the state for k edges. `STALL_CNT` advances by k.
- `CLEAR` and `IF_VALID` are sampled only on an advancing edge.

## Test plan
- Reset: drive `RST_N`=0 mid-run with `EXE` holding a LOAD → all IR=32'h13, VALID=0, `STALL_CNT`=0 immediately, no clock needed.
- Straight line: feed 32'h00500093 @PC 0x0, 32'h00A00113 @0x4, 32'h002081B3 @0x8 on consecutive cycles → 0x0 word reaches `WB_IR` after 4 edges, then 0x4 and 0x8 on the following edges. `PC_HOLD` stays 0.
- Load-use: EXE=32'h0000A103 (lw x2,0(x1)), DEC=32'h002081B3 (add x3,x1,x2) → `HAZARD`=1 and `PC_HOLD`=1 for one cycle. Next edge: EXE=bubble, DEC unchanged, MEM=lw. Then `HAZARD`=0 and the add advances. `STALL_CNT`=1.
- No false hazard: EXE=lw x2, DEC=32'h00200137 (lui x2) → `HAZARD`=0. EXE=lw x0 with DEC reading x0 → `HAZARD`=0.
- `CLEAR`: assert for one cycle with `IF_IR`=32'h00100293 → DEC becomes a bubble (VALID=0) while the previous DEC instruction enters EXE.
- Priority: `MEM_STALL`=1 for 3 cycles together with `HAZARD` and `CLEAR` → no stage changes and `STALL_CNT`+=3. Preload `STALL_CNT`=16'hFFFF and hold a stall → it remains 16'hFFFF.
